// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding
// and a counter-width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Width that can hold 0..bound inclusive.
    function automatic int cw(input int bound);
        return (bound < 1) ? 1 : $clog2(bound + 1);
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Board-facing signals of the reset sequencer: lock/button in,
// staggered channel resets and status out.
interface reset_seq_if #(
    parameter int N_OUT = 2
);
    logic             pll_lock;
    logic             btn;
    logic [N_OUT-1:0] rst_n_out;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output pll_lock,
        output btn,
        input  rst_n_out,
        input  busy,
        input  state
    );

    modport slave (
        input  pll_lock,
        input  btn,
        output rst_n_out,
        output busy,
        output state
    );
endinterface

// File: rtl/reset_seq_debounce.sv
// Button synchroniser plus stability counter; req_o is high
// while the debounced level equals POL.
module reset_seq_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter bit POL             = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic req_o
);

    localparam int W = cw(DEBOUNCE_CYCLES);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         s1_q;
    logic         s2_q;
    logic         lvl_q;
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= ~POL;
            cnt_q <= '0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            // Any return to the current level restarts the count.
            if (s2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                lvl_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign req_o = (lvl_q == POL);

endmodule

// File: rtl/reset_seq.sv
// Power-on/runtime reset sequencer: waits for stable lock, then
// releases N_OUT active-low resets one per STAGGER cycles.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int N_OUT           = 2,
    parameter int HOLD_CYCLES     = 65535,
    parameter int STAGGER         = 256,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter bit BTN_POL         = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    reset_seq_if.slave  bus
);

    localparam int HW = cw(HOLD_CYCLES);
    localparam int SW = cw(STAGGER);
    localparam int CW = cw(N_OUT);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(N_OUT - 1);

    logic             lock_s1_q;
    logic             lock_s_q;
    logic             req;
    logic             fault;
    logic             kill;
    state_e           state_q;
    logic [HW-1:0]    hold_cnt_q;
    logic [SW-1:0]    stag_cnt_q;
    logic [CW-1:0]    ch_idx_q;
    logic [N_OUT-1:0] out_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_s1_q <= 1'b0;
            lock_s_q  <= 1'b0;
        end else begin
            lock_s1_q <= bus.pll_lock;
            lock_s_q  <= lock_s1_q;
        end
    end

    reset_seq_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .POL             (BTN_POL)
    ) u_debounce (
        .clk   (clk),
        .rst_n (resetn),
        .btn_i (bus.btn),
        .req_o (req)
    );

    assign fault = !lock_s_q || req;
    // Fault outside HOLD drops every channel at once and wins
    // over a release due on the same edge.
    assign kill  = fault && (state_q != ST_HOLD);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            ch_idx_q   <= '0;
            out_q      <= '0;
            busy_q     <= 1'b1;
        end else if (kill) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            ch_idx_q   <= '0;
            out_q      <= '0;
            busy_q     <= 1'b1;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    stag_cnt_q <= '0;
                    ch_idx_q   <= '0;
                    if (fault) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_q <= '0;
                        if (N_OUT == 1) begin
                            out_q   <= '1;
                            busy_q  <= 1'b0;
                            state_q <= ST_RUN;
                        end else begin
                            out_q    <= N_OUT'(1);
                            ch_idx_q <= CW'(1);
                            state_q  <= ST_RELEASE;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (stag_cnt_q == STAG_LAST) begin
                        out_q      <= out_q | (N_OUT'(1) << ch_idx_q);
                        ch_idx_q   <= ch_idx_q + 1'b1;
                        stag_cnt_q <= '0;
                        if (ch_idx_q == CH_LAST) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end else begin
                        stag_cnt_q <= stag_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    out_q <= '1;
                end
                default: begin
                    state_q <= ST_HOLD;
                    out_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rst_n_out = out_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: N_OUT=3, HOLD=10, STAGGER=4,
// DEBOUNCE=5, button active-low.
module tb_reset_seq;

    localparam int N = 3;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    reset_seq_if #(.N_OUT(N)) bus ();

    reset_seq #(
        .N_OUT           (N),
        .HOLD_CYCLES     (10),
        .STAGGER         (4),
        .DEBOUNCE_CYCLES (5),
        .BTN_POL         (1'b0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic expect_o(input string tag,
                            input logic [2:0] o,
                            input logic b,
                            input logic [1:0] s);
        check({tag, "/out"}, 32'(bus.rst_n_out), 32'(o));
        check({tag, "/busy"}, 32'(bus.busy), 32'(b));
        check({tag, "/state"}, 32'(bus.state), 32'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) tick();
    endtask

    initial begin
        resetn       = 1'b0;
        bus.pll_lock = 1'b1;
        bus.btn      = 1'b1;
        repeat (3) tick();
        expect_o("rst", 3'b000, 1'b1, 2'd0);

        // Power-up release schedule
        resetn = 1'b1;
        cyc    = 0;
        run_to(11); expect_o("pu11", 3'b000, 1'b1, 2'd0);
        run_to(12); expect_o("pu12", 3'b001, 1'b1, 2'd1);
        run_to(15); expect_o("pu15", 3'b001, 1'b1, 2'd1);
        run_to(16); expect_o("pu16", 3'b011, 1'b1, 2'd1);
        run_to(19); expect_o("pu19", 3'b011, 1'b1, 2'd1);
        run_to(20); expect_o("pu20", 3'b111, 1'b0, 2'd2);

        // One-cycle lock loss at hold count 7
        resetn = 1'b0;
        #1;
        expect_o("rst2", 3'b000, 1'b1, 2'd0);
        tick();
        resetn = 1'b1;
        cyc    = 0;
        run_to(9);
        bus.pll_lock = 1'b0;
        run_to(10);
        bus.pll_lock = 1'b1;
        run_to(12); expect_o("lk12", 3'b000, 1'b1, 2'd0);
        run_to(21); expect_o("lk21", 3'b000, 1'b1, 2'd0);
        run_to(22); expect_o("lk22", 3'b001, 1'b1, 2'd1);
        run_to(30); expect_o("lk30", 3'b111, 1'b0, 2'd2);

        // Short press is filtered
        cyc     = 0;
        bus.btn = 1'b0;
        run_to(3);
        bus.btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("short", 32'(bus.rst_n_out), 32'h7);
        end

        // Long press, then replay after debounced release
        cyc     = 0;
        bus.btn = 1'b0;
        run_to(7);  expect_o("bt07", 3'b111, 1'b0, 2'd2);
        run_to(8);  expect_o("bt08", 3'b000, 1'b1, 2'd0);
        run_to(20);
        bus.btn = 1'b1;
        run_to(36); expect_o("bt36", 3'b000, 1'b1, 2'd0);
        run_to(37); expect_o("bt37", 3'b001, 1'b1, 2'd1);
        run_to(41); expect_o("bt41", 3'b011, 1'b1, 2'd1);

        // Lock loss lands on the channel-2 release edge
        run_to(42);
        bus.pll_lock = 1'b0;
        run_to(44); expect_o("ff44", 3'b011, 1'b1, 2'd1);
        run_to(45); expect_o("ff45", 3'b000, 1'b1, 2'd0);
        bus.pll_lock = 1'b1;
        run_to(56); expect_o("rc56", 3'b000, 1'b1, 2'd0);
        run_to(57); expect_o("rc57", 3'b001, 1'b1, 2'd1);
        run_to(59); expect_o("rc59", 3'b001, 1'b1, 2'd1);

        // Asynchronous reset mid-RELEASE, between clock edges
        #2;
        resetn = 1'b0;
        #1;
        expect_o("arst", 3'b000, 1'b1, 2'd0);
        tick();
        expect_o("arst2", 3'b000, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
